// File: rtl/hm10_alert_tx.sv
// Alert transmitter: reports every level change on N_CH alarm inputs to an HM-10 as "AL<ch><lvl>\r\n" over 8N1 UART.
// Pending channels are served round-robin. An optional periodic resend re-reports the channels that are still active.
module hm10_alert_tx #(
   parameter int CLOCK_FREQ    = 50_000_000,
   parameter int BAUD          = 9600,
   parameter int N_CH          = 4,
   parameter int REPEAT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] trigger,
   output logic            tx,
   output logic            busy,
   output logic            done,
   output logic [2:0]      done_ch
);

   localparam int DIV = CLOCK_FREQ / BAUD;
   localparam int CW  = $clog2(DIV + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t r_state, w_state_nxt;

   logic [N_CH-1:0] r_meta, r_sync, r_prev, r_pend, w_set, w_clr;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit, r_byte, r_ch, r_last, r_done_ch, w_sel;
   logic            r_lvl, r_tx, r_done;
   logic            w_any, w_load, w_fin, w_bit_end, w_wrap, w_tx_nxt;
   logic [7:0]      w_byte, w_sync_pad, w_pend_pad;

   generate
      if (REPEAT_CYCLES > 0) begin : g_rep
         logic [31:0] r_rep;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               r_rep <= '0;
            else if (r_rep == 32'(REPEAT_CYCLES - 1))
               r_rep <= '0;
            else
               r_rep <= r_rep + 32'd1;
         end
         assign w_wrap = (r_rep == 32'(REPEAT_CYCLES - 1));
      end else begin : g_norep
         assign w_wrap = 1'b0;
      end
   endgenerate

   // A new edge in the same cycle as the load keeps the channel pending.
   assign w_set = (r_sync ^ r_prev) | (w_wrap ? r_sync : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
         r_pend <= '0;
      end else begin
         r_meta <= trigger;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

   // Walking the search backwards leaves the channel closest after r_last selected.
   always_comb begin
      w_sync_pad             = '0;
      w_sync_pad[N_CH-1:0]   = r_sync;
      w_pend_pad             = '0;
      w_pend_pad[N_CH-1:0]   = r_pend;
      w_any                  = |r_pend;
      w_sel                  = '0;
      for (int k = N_CH; k >= 1; k--) begin
         if (w_pend_pad[3'((int'(r_last) + k) % N_CH)])
            w_sel = 3'((int'(r_last) + k) % N_CH);
      end
   end

   always_comb begin
      w_clr = '0;
      for (int i = 0; i < N_CH; i++)
         w_clr[i] = w_load && (w_sel == 3'(i));
   end

   always_comb begin
      case (r_byte)
         3'd0:    w_byte = 8'h41;
         3'd1:    w_byte = 8'h4C;
         3'd2:    w_byte = 8'h30 + {5'b0, r_ch};
         3'd3:    w_byte = 8'h30 + {7'b0, r_lvl};
         3'd4:    w_byte = 8'h0D;
         default: w_byte = 8'h0A;
      endcase
   end

   assign w_bit_end = (r_cnt == CW'(DIV - 1));

   // tx is registered from the value the line carries in the next state.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_fin       = 1'b0;
      w_tx_nxt    = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_load      = 1'b1;
               w_state_nxt = START;
               w_tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt = DATA;
               w_tx_nxt    = w_byte[0];
            end else begin
               w_tx_nxt    = 1'b0;
            end
         end
         DATA: begin
            if (w_bit_end && r_bit == 3'd7)
               w_state_nxt = STOP;
            else if (w_bit_end)
               w_tx_nxt = w_byte[r_bit + 3'd1];
            else
               w_tx_nxt = w_byte[r_bit];
         end
         STOP: begin
            if (w_bit_end) begin
               if (r_byte == 3'd5) begin
                  w_state_nxt = IDLE;
                  w_fin       = 1'b1;
               end else begin
                  w_state_nxt = START;
                  w_tx_nxt    = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_byte    <= '0;
         r_ch      <= '0;
         r_lvl     <= 1'b0;
         r_last    <= 3'(N_CH - 1);
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
         r_done_ch <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_done  <= w_fin;
         if (w_fin)
            r_done_ch <= r_ch;
         if (r_state == IDLE || w_bit_end)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CW'(1);
         if (w_load) begin
            r_ch   <= w_sel;
            r_lvl  <= w_sync_pad[w_sel];
            r_last <= w_sel;
            r_byte <= '0;
            r_bit  <= '0;
         end else begin
            if (r_state == DATA && w_bit_end)
               r_bit <= r_bit + 3'd1;
            if (r_state == STOP && w_bit_end && r_byte != 3'd5)
               r_byte <= r_byte + 3'd1;
         end
      end
   end

   assign tx      = r_tx;
   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign done_ch = r_done_ch;

endmodule

// File: tb/tb_hm10_alert_tx.sv
// Bench for hm10_alert_tx: a UART line decoder turns tx into bytes; expected messages come from a round-robin event model.
// A second instance with periodic resend enabled is exercised only in test_resend.
module tb_hm10_alert_tx;

   localparam int DIV = 10;
   localparam int N   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1, rst_r = 1'b1;
   logic [3:0] trig = '0, trig_r = '0;
   logic       tx, busy, done, tx_r, busy_r, done_r;
   logic [2:0] done_ch, done_ch_r;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_m = N - 1;
   logic mon_sel = 1'b0;
   logic mon_tx;

   logic [7:0] rx_q[$];
   int         rx_t[$];

   hm10_alert_tx #(.CLOCK_FREQ(100), .BAUD(10), .N_CH(4), .REPEAT_CYCLES(0)) dut (
      .clk(clk), .rst(rst), .trigger(trig),
      .tx(tx), .busy(busy), .done(done), .done_ch(done_ch));

   hm10_alert_tx #(.CLOCK_FREQ(100), .BAUD(10), .N_CH(4), .REPEAT_CYCLES(2000)) dut_r (
      .clk(clk), .rst(rst_r), .trigger(trig_r),
      .tx(tx_r), .busy(busy_r), .done(done_r), .done_ch(done_ch_r));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mon_tx = mon_sel ? tx_r : tx;

   // Line decoder: samples mid-bit on falling clock edges; stamps each byte with the edge its start bit began on.
   initial begin
      int t0;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_tx === 1'b0) begin
            t0 = cyc;
            b  = '0;
            repeat (DIV / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = mon_tx;
            end
            repeat (DIV) @(negedge clk);
            rx_q.push_back(b);
            rx_t.push_back(t0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
      $fatal(1);
   end

   function automatic logic [47:0] msg_exp(input int c, input int l);
      return {8'h41, 8'h4C, 8'h30 + 8'(c), 8'h30 + 8'(l), 8'h0D, 8'h0A};
   endfunction

   task automatic get_msg(output logic [47:0] m, output int t, output bit ok);
      int n = 0;
      while (rx_q.size() < 6 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      ok = (rx_q.size() >= 6);
      m  = '0;
      t  = -1;
      if (ok) begin
         t = rx_t[0];
         for (int i = 0; i < 6; i++) begin
            m = {m[39:0], rx_q.pop_front()};
            void'(rx_t.pop_front());
         end
      end
   endtask

   task automatic do_reset();
      trig = '0;
      rst  = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      repeat (1100) @(posedge clk);
      #1;
      rx_q.delete();
      rx_t.delete();
      last_m = N - 1;
   endtask

   task automatic test_reset();
      int bad = 0;
      trig = '0;
      rst  = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || done_ch !== 3'd0) begin
         errors++;
         $display("FAIL reset_vals: tx=%b busy=%b done=%b done_ch=%0d, required 1 0 0 0", tx, busy, done, done_ch);
      end
      rst = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_idle: %0d non-idle cycles, required 0", bad);
      end
   endtask

   task automatic test_single_edge();
      int fall_n = -1, busy_n = 0, done_n = 0, done_at = -1, t;
      logic [2:0] dch = '0;
      logic [47:0] m;
      bit ok;
      trig[2] = 1'b1;
      for (int n = 1; n <= 700; n++) begin
         @(posedge clk); #1;
         if (tx === 1'b0 && fall_n < 0) fall_n = n;
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) begin
            done_n++;
            done_at = n;
            dch     = done_ch;
         end
      end
      checks++;
      if (fall_n !== 4) begin errors++; $display("FAIL single_latency: tx fell at edge %0d, required 4", fall_n); end
      checks++;
      if (busy_n !== 600) begin errors++; $display("FAIL single_busy: busy for %0d cycles, required 600", busy_n); end
      checks++;
      if (done_n !== 1 || done_at !== 604) begin
         errors++;
         $display("FAIL single_done: %0d pulses, last at edge %0d, required 1 at 604", done_n, done_at);
      end
      checks++;
      if (dch !== 3'd2) begin errors++; $display("FAIL single_done_ch: got %0d required 2", dch); end
      get_msg(m, t, ok);
      checks++;
      if (!ok || m !== msg_exp(2, 1)) begin
         errors++;
         $display("FAIL single_msg: got %h required %h", m, msg_exp(2, 1));
      end
   endtask

   task automatic test_simultaneous();
      logic [47:0] m1, m2;
      int t1, t2;
      bit ok1, ok2;
      do_reset();
      trig[0] = 1'b1;
      trig[3] = 1'b1;
      get_msg(m1, t1, ok1);
      get_msg(m2, t2, ok2);
      checks++;
      if (!ok1 || m1 !== msg_exp(0, 1)) begin errors++; $display("FAIL simul_first: got %h required %h", m1, msg_exp(0, 1)); end
      checks++;
      if (!ok2 || m2 !== msg_exp(3, 1)) begin errors++; $display("FAIL simul_second: got %h required %h", m2, msg_exp(3, 1)); end
      checks++;
      if (t2 - t1 !== 601) begin errors++; $display("FAIL simul_gap: start bits %0d apart, required 601", t2 - t1); end
   endtask

   task automatic test_fall_during();
      logic [47:0] m;
      int t, w = 0;
      bit ok;
      do_reset();
      trig[1] = 1'b1;
      while (tx !== 1'b0 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL fall_start: tx=%b after %0d cycles, required 0", tx, w); end
      repeat (100) @(posedge clk);
      #1 trig[1] = 1'b0;
      get_msg(m, t, ok);
      checks++;
      if (!ok || m !== msg_exp(1, 1)) begin errors++; $display("FAIL fall_rise_msg: got %h required %h", m, msg_exp(1, 1)); end
      get_msg(m, t, ok);
      checks++;
      if (!ok || m !== msg_exp(1, 0)) begin errors++; $display("FAIL fall_fall_msg: got %h required %h", m, msg_exp(1, 0)); end
      // Short pulse on ch1 entirely while ch0 is on the line: both edges merge into one pending event.
      repeat (20) @(posedge clk);
      #1 trig[0] = 1'b1;
      repeat (50) @(posedge clk);
      #1 trig[1] = 1'b1;
      repeat (3) @(posedge clk);
      #1 trig[1] = 1'b0;
      get_msg(m, t, ok);
      checks++;
      if (!ok || m !== msg_exp(0, 1)) begin errors++; $display("FAIL pulse_other_msg: got %h required %h", m, msg_exp(0, 1)); end
      get_msg(m, t, ok);
      checks++;
      if (!ok || m !== msg_exp(1, 0)) begin errors++; $display("FAIL pulse_msg: got %h required %h", m, msg_exp(1, 0)); end
      repeat (1500) @(posedge clk);
      #1;
      checks++;
      if (rx_q.size() !== 0) begin errors++; $display("FAIL pulse_extra: %0d extra bytes, required 0", rx_q.size()); end
   endtask

   task automatic test_random();
      logic [3:0] lv = '0;
      logic [3:0] mask;
      logic [47:0] m;
      int t, tprev, c;
      int order[$];
      bit ok;
      do_reset();
      for (int it = 0; it < 6; it++) begin
         c      = $urandom_range(0, N - 1);
         lv[c]  = ~lv[c];
         trig   = lv;
         get_msg(m, t, ok);
         checks++;
         if (!ok || m !== msg_exp(c, int'(lv[c]))) begin
            errors++;
            $display("FAIL rand_single: got %h required %h", m, msg_exp(c, int'(lv[c])));
         end
         last_m = c;
         repeat (20) @(posedge clk);
         #1;
      end
      for (int bt = 0; bt < 3; bt++) begin
         mask = 4'($urandom_range(1, 15));
         lv   = lv ^ mask;
         trig = lv;
         order.delete();
         for (int k = 1; k <= N; k++)
            if (mask[(last_m + k) % N]) order.push_back((last_m + k) % N);
         tprev = -1;
         foreach (order[j]) begin
            get_msg(m, t, ok);
            checks++;
            if (!ok || m !== msg_exp(order[j], int'(lv[order[j]]))) begin
               errors++;
               $display("FAIL rand_batch: got %h required %h", m, msg_exp(order[j], int'(lv[order[j]])));
            end
            if (tprev >= 0) begin
               checks++;
               if (t - tprev !== 601) begin errors++; $display("FAIL rand_gap: %0d apart, required 601", t - tprev); end
            end
            tprev  = t;
            last_m = order[j];
         end
         repeat (20) @(posedge clk);
         #1;
      end
   endtask

   task automatic test_resend();
      logic [47:0] m;
      int t[3];
      int c0;
      bit ok;
      mon_sel = 1'b1;
      rx_q.delete();
      rx_t.delete();
      trig_r = 4'b0010;
      rst_r  = 1'b1;
      @(posedge clk);
      #1 rst_r = 1'b0;
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         get_msg(m, t[i], ok);
         checks++;
         if (!ok || m !== msg_exp(1, 1)) begin errors++; $display("FAIL resend_msg%0d: got %h required %h", i, m, msg_exp(1, 1)); end
      end
      checks++;
      if (t[0] !== c0 + 4) begin errors++; $display("FAIL resend_first: start at %0d, required %0d", t[0], c0 + 4); end
      checks++;
      if (t[2] - t[1] !== 2000) begin errors++; $display("FAIL resend_period: %0d apart, required 2000", t[2] - t[1]); end
      rst_r = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      mon_sel = 1'b0;
      rx_q.delete();
      rx_t.delete();
   endtask

   task automatic test_reset_mid();
      int w = 0, bad = 0;
      do_reset();
      trig[3] = 1'b1;
      while (tx !== 1'b0 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      checks++;
      if (tx !== 1'b0) begin errors++; $display("FAIL mid_start: tx=%b after %0d cycles, required 0", tx, w); end
      repeat (250) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_async: tx=%b busy=%b, required 1 0", tx, busy); end
      trig = '0;
      repeat (5) begin
         @(posedge clk); #1;
         if (done !== 1'b0) bad++;
      end
      rst = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL mid_after: %0d active cycles, required 0", bad); end
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_simultaneous();
      test_fall_during();
      test_random();
      test_resend();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
